// File: rtl/fifo_unload_pkg.sv
// Shared types and constants for the FIFO unload framer: state encoding,
// frame tags and channel geometry.
package fifo_unload_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HEADER  = 2'b01,
    DATA    = 2'b10,
    TRAILER = 2'b11
  } state_t;

  localparam logic [3:0] HDR_TAG       = 4'hB;
  localparam logic [3:0] TRL_TAG       = 4'hE;
  localparam int         CHAN_PER_SAMP = 6;
  localparam int         TMO_MAX_DEF   = 255;

  localparam logic [2:0] LAST_CHAN = 3'(CHAN_PER_SAMP - 1);

endpackage

// File: rtl/evt_pend_ctr.sv
// Saturating up/down counter of announced-but-unstarted events, with a sticky
// overflow flag for announcements lost while saturated.
module evt_pend_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc && !dec) begin
      if (cnt == CNT_MAX) ovf <= 1'b1;
      else                cnt <= cnt + W'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/fifo_unload_fsm.sv
// Unloads one event at a time from a first-word-fall-through FIFO and frames
// it for the link as header, (SAMP_MAX+1)*6 data words and a trailer.
module fifo_unload_fsm
  import fifo_unload_pkg::*;
#(
  parameter int TMO_MAX = TMO_MAX_DEF,
  parameter int PEND_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [6:0]        SAMP_MAX,
  input  logic              EVT_RDY,
  input  logic              FIFO_EMPTY,
  input  logic [11:0]       FIFO_DOUT,
  output logic              FIFO_RDENA,
  output logic [15:0]       TX_DATA,
  output logic              TX_VLD,
  input  logic              TX_RDY,
  output logic              TX_SOF,
  output logic              TX_EOF,
  output logic [PEND_W-1:0] EVT_PEND,
  output logic              PEND_OVF
);

  localparam int             TMO_W    = $clog2(TMO_MAX + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  state_t            state, next_state;
  logic [6:0]        samp_max_q;
  logic [6:0]        samp;
  logic [2:0]        chan;
  logic [11:0]       sum;
  logic [11:0]       evt_num;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              abort;
  logic              start;
  logic              accept;
  logic              pop;
  logic              last_word;

  evt_pend_ctr #(.W(PEND_W)) u_pend (
    .clk (CLK),
    .rst (RST),
    .inc (EVT_RDY),
    .dec (start),
    .cnt (EVT_PEND),
    .ovf (PEND_OVF)
  );

  assign last_word  = (chan == LAST_CHAN) && (samp == samp_max_q);
  assign accept     = TX_VLD && TX_RDY;
  assign pop        = (state == DATA) && accept;
  assign FIFO_RDENA = pop;

  // Outputs decode from registered state only (plus the FIFO head in DATA),
  // so a stalled word cannot change until it is accepted.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves a value unassigned and infers a latch.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    TX_VLD     = 1'b0;
    TX_SOF     = 1'b0;
    TX_EOF     = 1'b0;
    TX_DATA    = 16'h0000;
    case (state)
      IDLE: begin
        if (EVT_PEND != '0) begin
          start      = 1'b1;
          next_state = HEADER;
        end
      end
      HEADER: begin
        TX_VLD  = 1'b1;
        TX_SOF  = 1'b1;
        TX_DATA = {HDR_TAG, evt_num};
        if (TX_RDY) next_state = DATA;
      end
      DATA: begin
        TX_VLD  = !FIFO_EMPTY;
        TX_DATA = {1'b0, chan, FIFO_DOUT};
        if (!FIFO_EMPTY && TX_RDY && last_word)  next_state = TRAILER;
        else if (FIFO_EMPTY && tmo_cnt == TMO_LAST) next_state = TRAILER;
      end
      TRAILER: begin
        TX_VLD  = 1'b1;
        TX_EOF  = 1'b1;
        TX_DATA = {TRL_TAG, abort, sum[10:0]};
        if (TX_RDY) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      samp_max_q <= '0;
      samp       <= '0;
      chan       <= '0;
      sum        <= '0;
      evt_num    <= '0;
      tmo_cnt    <= '0;
      abort      <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        HEADER: begin
          if (accept) begin
            samp_max_q <= SAMP_MAX;
            samp       <= '0;
            chan       <= '0;
            sum        <= '0;
            tmo_cnt    <= '0;
            abort      <= 1'b0;
          end
        end
        DATA: begin
          if (pop) begin
            sum     <= sum + FIFO_DOUT;
            tmo_cnt <= '0;
            if (chan == LAST_CHAN) begin
              chan <= '0;
              samp <= samp + 7'd1;
            end else begin
              chan <= chan + 3'd1;
            end
          end else if (FIFO_EMPTY) begin
            // Final empty cycle flags the abort instead of counting further.
            if (tmo_cnt == TMO_LAST) abort   <= 1'b1;
            else                     tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        TRAILER: begin
          if (accept) evt_num <= evt_num + 12'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_unload_fsm.sv
// Directed bench for fifo_unload_fsm: a small FWFT FIFO model feeds the DUT and
// accepted link words are captured and compared against hand-computed frames.
module tb_fifo_unload_fsm;

  logic        CLK = 1'b0;
  logic        RST;
  logic [6:0]  SAMP_MAX;
  logic        EVT_RDY;
  logic        FIFO_EMPTY;
  logic [11:0] FIFO_DOUT;
  logic        FIFO_RDENA;
  logic [15:0] TX_DATA;
  logic        TX_VLD;
  logic        TX_RDY;
  logic        TX_SOF;
  logic        TX_EOF;
  logic [3:0]  EVT_PEND;
  logic        PEND_OVF;

  logic [11:0] fifo_mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  int          underflow = 0;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          rdy_toggle = 1'b0;
  logic [15:0] cap [$];
  int          pops, gaps, stable_err;
  bit          timed_out;
  int          vld_seen;

  logic [15:0] exp1 [8] = '{16'hB000, 16'h0001, 16'h1002, 16'h2003,
                            16'h3004, 16'h4005, 16'h5006, 16'hE015};

  fifo_unload_fsm #(.TMO_MAX(255), .PEND_W(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SAMP_MAX   (SAMP_MAX),
    .EVT_RDY    (EVT_RDY),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_DOUT  (FIFO_DOUT),
    .FIFO_RDENA (FIFO_RDENA),
    .TX_DATA    (TX_DATA),
    .TX_VLD     (TX_VLD),
    .TX_RDY     (TX_RDY),
    .TX_SOF     (TX_SOF),
    .TX_EOF     (TX_EOF),
    .EVT_PEND   (EVT_PEND),
    .PEND_OVF   (PEND_OVF)
  );

  always #5 CLK = ~CLK;

  assign FIFO_EMPTY = (rd_ptr == wr_ptr);
  assign FIFO_DOUT  = fifo_mem[rd_ptr];

  always @(posedge CLK) begin
    if (FIFO_RDENA) begin
      if (FIFO_EMPTY) underflow <= underflow + 1;
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic step();
    @(negedge CLK);
    if (rdy_toggle) TX_RDY = ~TX_RDY;
    #1;
  endtask

  task automatic push(input logic [11:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic pulse();
    EVT_RDY = 1'b1;
    step();
    EVT_RDY = 1'b0;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  // Captures accepted words until the trailer is accepted; SAMP_MAX is moved
  // to samp_late once the header has gone, to prove it was latched.
  task automatic run_frame(input int budget, input logic [6:0] samp_late);
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_sof, prev_eof;
    int          cycles;
    cap.delete();
    pops = 0; gaps = 0; stable_err = 0; timed_out = 1'b0; cycles = 0;
    prev_stall = 1'b0; prev_data = '0; prev_sof = 1'b0; prev_eof = 1'b0;
    while (1) begin
      if (cap.size() > 0) SAMP_MAX = samp_late;
      if (prev_stall && (!TX_VLD || TX_DATA !== prev_data ||
                         TX_SOF !== prev_sof || TX_EOF !== prev_eof)) stable_err++;
      if (TX_SOF && TX_EOF) stable_err++;
      if (FIFO_RDENA) pops++;
      if (cap.size() > 0 && !TX_VLD) gaps++;
      if (TX_VLD && TX_RDY) begin
        cap.push_back(TX_DATA);
        if (TX_EOF) break;
      end
      prev_stall = TX_VLD && !TX_RDY;
      prev_data  = TX_DATA;
      prev_sof   = TX_SOF;
      prev_eof   = TX_EOF;
      cycles++;
      if (cycles > budget) begin
        timed_out = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    RST = 1'b1; EVT_RDY = 1'b0; TX_RDY = 1'b0; SAMP_MAX = 7'd0;

    // Reset state
    apply_reset();
    check("rst_outputs", {TX_VLD, TX_SOF, TX_EOF, FIFO_RDENA, PEND_OVF, EVT_PEND, TX_DATA}, 32'h0);

    // Single event, SAMP_MAX=0, link always ready
    TX_RDY = 1'b1;
    for (int i = 1; i <= 6; i++) push(12'(i));
    pulse();
    run_frame(100, 7'd0);
    check("t1_timeout", timed_out, 0);
    check("t1_words", cap.size(), 8);
    for (int k = 0; k < 8; k++) check($sformatf("t1_word%0d", k), cap[k], exp1[k]);
    check("t1_pops", pops, 6);
    check("t1_gaps", gaps, 0);
    step();
    check("t1_idle_vld", TX_VLD, 0);
    check("t1_pend", EVT_PEND, 0);

    // Two back-to-back events, SAMP_MAX=2, link ready toggling every cycle
    TX_RDY = 1'b0;
    apply_reset();
    SAMP_MAX = 7'd2;
    for (int i = 1; i <= 18; i++) push(12'(i));
    for (int i = 0; i < 18; i++) push(12'hFFF);
    pulse();
    step();
    EVT_RDY = 1'b1;
    step();
    EVT_RDY = 1'b0;
    check("t2_pend_during_evt", EVT_PEND, 1);
    rdy_toggle = 1'b1;
    run_frame(200, 7'd7);
    SAMP_MAX = 7'd2;
    check("t2a_timeout", timed_out, 0);
    check("t2a_words", cap.size(), 20);
    check("t2a_hdr", cap[0], 16'hB000);
    check("t2a_d0", cap[1], 16'h0001);
    check("t2a_d6", cap[7], 16'h0007);
    check("t2a_d11", cap[12], 16'h500C);
    check("t2a_d17", cap[18], 16'h5012);
    check("t2a_trl", cap[19], 16'hE0AB);
    check("t2a_pops", pops, 18);
    check("t2a_stable", stable_err, 0);
    step();
    check("t2_idle_vld", TX_VLD, 0);
    check("t2_idle_pend", EVT_PEND, 1);
    step();
    check("t2_hdr_sof", {TX_VLD, TX_SOF, TX_EOF}, 3'b110);
    check("t2_hdr_pend", EVT_PEND, 0);
    run_frame(200, 7'd2);
    check("t2b_timeout", timed_out, 0);
    check("t2b_words", cap.size(), 20);
    check("t2b_hdr", cap[0], 16'hB001);
    check("t2b_d0", cap[1], 16'h0FFF);
    check("t2b_d17", cap[18], 16'h5FFF);
    check("t2b_trl_wrap", cap[19], 16'hE7EE);
    check("t2b_pops", pops, 18);
    check("t2b_stable", stable_err, 0);
    rdy_toggle = 1'b0;

    // FIFO runs dry after 4 words: abort after 255 empty cycles
    TX_RDY = 1'b0;
    apply_reset();
    TX_RDY = 1'b1;
    SAMP_MAX = 7'd0;
    push(12'h100); push(12'h200); push(12'h300); push(12'h7FF);
    pulse();
    run_frame(600, 7'd0);
    check("t3_timeout", timed_out, 0);
    check("t3_words", cap.size(), 6);
    check("t3_hdr", cap[0], 16'hB000);
    check("t3_d3", cap[4], 16'h37FF);
    check("t3_trl_abort", cap[5], 16'hEDFF);
    check("t3_gaps", gaps, 255);
    check("t3_pops", pops, 4);
    step();
    check("t3_idle_vld", TX_VLD, 0);

    // Reset in the middle of DATA: no trailer, evt_num back to 0
    for (int i = 1; i <= 6; i++) push(12'h0A0 + 12'(i));
    pulse();
    step();
    check("t5_hdr", {TX_SOF, TX_DATA}, {1'b1, 16'hB001});
    step();
    step();
    check("t5_d1", TX_DATA, 16'h10A2);
    RST = 1'b1;
    step();
    check("t5_rst_outputs", {TX_VLD, TX_SOF, TX_EOF, FIFO_RDENA, PEND_OVF, EVT_PEND, TX_DATA}, 32'h0);
    RST = 1'b0;
    vld_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (TX_VLD || TX_EOF) vld_seen++;
    end
    check("t5_no_trailer", vld_seen, 0);
    pulse();
    step();
    check("t5_next_hdr", {TX_SOF, TX_DATA}, {1'b1, 16'hB000});

    // Pending counter saturation and overflow, link stalled
    TX_RDY = 1'b0;
    apply_reset();
    pulse();
    check("t4_pend1", EVT_PEND, 1);
    EVT_RDY = 1'b1;
    step();
    EVT_RDY = 1'b0;
    check("t4_coincide", {TX_SOF, EVT_PEND}, {1'b1, 4'd1});
    for (int i = 3; i <= 16; i++) begin
      pulse();
      step();
    end
    check("t4_sat_no_ovf", {PEND_OVF, EVT_PEND}, {1'b0, 4'd15});
    pulse();
    check("t4_ovf", {PEND_OVF, EVT_PEND}, {1'b1, 4'd15});
    check("t4_stalled_hdr", {TX_VLD, TX_DATA}, {1'b1, 16'hB000});

    check("fifo_underflow", underflow, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_unload_fsm.md
FIFO_UNLOAD_FSM -- requirements
Module: fifo_unload_fsm

Interface
REQ-001 Parameter TMO_MAX, default 255: consecutive FIFO-empty cycles in DATA before an event is aborted.
REQ-002 Parameter PEND_W, default 4: width of the pending-event counter.
REQ-003 CLK  in  1  single clock; all logic on its rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 SAMP_MAX  in  7  index of the last sample per event; the same value the load stage uses.
REQ-006 EVT_RDY  in  1  one-cycle pulse: one complete event (SAMP_MAX+1 samples x 6 channels) has been written to the FIFO.
REQ-007 FIFO_EMPTY  in  1  first-word-fall-through FIFO empty flag.
REQ-008 FIFO_DOUT  in  12  FIFO head word, valid when FIFO_EMPTY=0.
REQ-009 FIFO_RDENA  out  1  pop strobe; asserted only when a data word is accepted downstream.
REQ-010 TX_DATA  out  16  link word.
REQ-011 TX_VLD  out  1  TX_DATA valid.
REQ-012 TX_RDY  in  1  link accepts the word when TX_VLD=1 and TX_RDY=1.
REQ-013 TX_SOF, TX_EOF  out  1 each  qualify the header word and the trailer word.
REQ-014 EVT_PEND  out  PEND_W  count of events announced but not yet started.
REQ-015 PEND_OVF  out  1  sticky flag: EVT_RDY arrived while EVT_PEND was saturated.

Function
REQ-016 States: IDLE, HEADER, DATA, TRAILER. Encoding 2'b00..2'b11 in that order.
REQ-017 IDLE -> HEADER when EVT_PEND>0; EVT_PEND decrements on that cycle.
REQ-018 HEADER: drive TX_DATA={4'hB, evt_num[11:0]} with TX_SOF=1. On acceptance, latch SAMP_MAX, clear the channel, sample, sum and timeout counters, then go to DATA.
REQ-019 DATA: when FIFO_EMPTY=0, present TX_DATA={1'b0, chan[2:0], FIFO_DOUT}. FIFO_RDENA=TX_VLD & TX_RDY in DATA; the pop and the acceptance occur in the same cycle.
REQ-020 Each accepted data word increments chan from 0 to 5. After chan 5, chan wraps to 0 and the sample index increments.
REQ-021 The 12-bit sum accumulates FIFO_DOUT of each accepted word, modulo 4096.
REQ-022 DATA -> TRAILER on acceptance of the word with chan=5 and sample=latched SAMP_MAX. An event is (SAMP_MAX+1)*6 words, maximum 768, tracked with a 10-bit word count.
REQ-023 While in DATA with FIFO_EMPTY=1: TX_VLD=0 and the timeout counter increments. The counter clears on any accepted word.
REQ-024 When the timeout counter reaches TMO_MAX: go to TRAILER with the abort flag set.
REQ-025 TRAILER: TX_DATA={4'hE, abort, sum[10:0]} with TX_EOF=1. On acceptance, evt_num increments (mod 4096) and the FSM goes to IDLE.
REQ-026 Handshake: while TX_VLD=1 and TX_RDY=0, TX_DATA, TX_SOF and TX_EOF hold stable. TX_VLD never deasserts without acceptance, except on RST.
REQ-027 TX_VLD=0 in IDLE. TX_SOF and TX_EOF are never both 1.
REQ-028 EVT_PEND: +1 on EVT_RDY, -1 on event start.
REQ-029 EVT_RDY coinciding with an event start leaves EVT_PEND unchanged.
REQ-030 EVT_PEND saturates at 2^PEND_W-1. An EVT_RDY while saturated (and no simultaneous start) sets PEND_OVF.
REQ-031 Back-to-back events: IDLE lasts exactly one cycle when EVT_PEND>0 on trailer acceptance.
REQ-032 SAMP_MAX changes after HEADER do not affect the current event.

Reset
REQ-033 RST overrides all other inputs and takes effect at the next CLK edge.
REQ-034 RST sets: state=IDLE, TX_VLD=0, TX_SOF=0, TX_EOF=0, TX_DATA=0, FIFO_RDENA=0, EVT_PEND=0, PEND_OVF=0, evt_num=0, and all counters and the sum to 0.
REQ-035 RST mid-event abandons the event without emitting a trailer. FIFO contents are not flushed by this block.

Structure
REQ-036 Package fifo_unload_pkg holds: state encoding, HDR_TAG=4'hB, TRL_TAG=4'hE, CHAN_PER_SAMP=6, and the default TMO_MAX.
REQ-037 One sub-module, evt_pend_ctr: the saturating up/down pending counter with the overflow flag.
REQ-038 Target size 150-300 lines of RTL in total.

Verification
REQ-039 SAMP_MAX=0, one EVT_RDY, FIFO preloaded with 6 words 0x001..0x006, TX_RDY=1 -> frame B000, 0001, 1002, 2003, 3004, 4005, 5006, E015; 8 words total; 6 pops.
REQ-040 SAMP_MAX=2, TX_RDY toggling 1/0 every cycle -> 20 words total, TX_DATA stable whenever stalled, exactly 18 FIFO_RDENA pulses; second event header = B001.
REQ-041 FIFO runs empty after 4 data words and stays empty, TMO_MAX=255 -> after 255 empty cycles, trailer has the abort bit set (TX_DATA[11]=1) with the sum of the 4 words; FSM returns to IDLE.
REQ-042 17 EVT_RDY pulses with TX_RDY=0 -> EVT_PEND=15 and PEND_OVF=1; EVT_RDY on the same cycle as an event start leaves EVT_PEND unchanged.
REQ-043 RST asserted during DATA -> next cycle: all outputs are at reset values, no trailer is emitted, and the next event header = B000.
